// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared state encoding, width defaults and HALT-entry policy for the imem port arbiter
package imem_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {RUN, HOST, HALT} state_t;
  // A fresh host_req meeting halt_req in RUN is not granted there; HALT is entered first and serves it
  localparam bit HALT_BEFORE_GRANT = 1'b1;
endpackage

// File: rtl/imem_arb_stats.sv
// imem_arb_stats: fetch/stall cycle counters for the imem port arbiter
// Ports: clk, clrn (async active-low reset), cpu_stall, cpu_rstn (observed CPU handshake),
//        fetch_cnt (cycles delivering an instruction), stall_cnt (cycles the running CPU is held).
module imem_arb_stats (
  input  logic        clk,
  input  logic        clrn,
  input  logic        cpu_stall,
  input  logic        cpu_rstn,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(cpu_rstn && !cpu_stall);
      stall_cnt <= stall_cnt + 32'(cpu_rstn && cpu_stall);
    end
endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one instruction block-memory port between the CPU fetch path and a host
// Ports: clk, clrn (async active-low reset); cpu_addr/cpu_inst/cpu_stall/cpu_rstn (CPU fetch side);
//        halt_req/halted (host halt control); host_req/host_we/host_addr/host_wdata/host_ack/host_rdata
//        (host access); mem_we/mem_addr/mem_din/mem_dout (block memory, one-cycle registered read).
// Optional: define IMEM_ARB_STATS_EN to add fetch_cnt/stall_cnt outputs.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_inst,
  output logic              cpu_stall,
  output logic              cpu_rstn,
  input  logic              halt_req,
  output logic              halted,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);
  state_t state, state_nx;
  logic grant, fetch, ack_q, fetch_q;
  logic [ADDR_W-1:0] addr_q;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state    <= RUN;
      ack_q    <= 1'b0;
      fetch_q  <= 1'b0;
      addr_q   <= '0;
      cpu_rstn <= 1'b0;
    end else begin
      state    <= state_nx;
      ack_q    <= grant;
      fetch_q  <= fetch;
      addr_q   <= cpu_addr;
      cpu_rstn <= state_nx != HALT;
    end
  // HALT is left only once the last granted access has been acked
  always_comb
    state_nx = state == RUN  ? (grant ? HOST : halt_req ? HALT : RUN) :
               state == HOST ? (halt_req ? HALT : RUN) :
               (halt_req || ack_q) ? HALT : RUN;
  // clrn gates the grant so a request presented during reset cannot write memory.
  // A granted cycle stalls the CPU even when cpu_inst is valid: consuming it would move the PC into a
  // cycle with no fetch behind it, and a host write may be replacing the word being fetched.
  always_comb begin
    grant      = clrn && host_req && (state == HALT ? halt_req : state == RUN && !(HALT_BEFORE_GRANT && halt_req));
    fetch      = !grant && state != HALT;
    mem_addr   = grant ? host_addr : cpu_addr;
    mem_we     = grant && host_we;
    mem_din    = host_wdata;
    host_ack   = ack_q;
    host_rdata = mem_dout;
    cpu_inst   = mem_dout;
    cpu_stall  = grant || !(fetch_q && addr_q == cpu_addr);
    halted     = state == HALT;
  end
`ifdef IMEM_ARB_STATS_EN
  imem_arb_stats u_stats (
    .clk       (clk),
    .clrn      (clrn),
    .cpu_stall (cpu_stall),
    .cpu_rstn  (cpu_rstn),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );
`endif
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: table, directed and randomized checks of imem_port_arbiter against a behavioural BRAM
module tb_imem_port_arbiter;
  logic clk = 1'b0, clrn = 1'b0, load = 1'b1;
  logic [7:0] cpu_addr = '0, host_addr = '0, mem_addr;
  logic [31:0] cpu_inst, host_wdata = '0, host_rdata, mem_din, mem_dout;
  logic cpu_stall, cpu_rstn, halted, host_ack, mem_we;
  logic halt_req = 1'b0, host_req = 1'b0, host_we = 1'b0;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif
  logic [31:0] mem [256];
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [7:0]  ca;
    logic [2:0]  in;
    logic [7:0]  ha;
    logic [31:0] wd;
    logic [7:0]  ma;
    logic [4:0]  ex;
    logic        dv;
    logic [31:0] d;
  } vec_t;
  vec_t tv [24];
  always #5 clk = ~clk;
  imem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .clrn(clrn), .cpu_addr(cpu_addr), .cpu_inst(cpu_inst), .cpu_stall(cpu_stall),
    .cpu_rstn(cpu_rstn), .halt_req(halt_req), .halted(halted), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef IMEM_ARB_STATS_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );
  always @(posedge clk)
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
    end else begin
      if (mem_we) mem[mem_addr] <= mem_din;
      mem_dout <= mem[mem_addr];
    end
  function automatic vec_t mk(logic [7:0] ca, logic [2:0] in, logic [7:0] ha, logic [31:0] wd,
                              logic [7:0] ma, logic [4:0] ex, logic dv, logic [31:0] d);
    mk.ca = ca; mk.in = in; mk.ha = ha; mk.wd = wd; mk.ma = ma; mk.ex = ex; mk.dv = dv; mk.d = d;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  initial begin
    logic [31:0] mm [256];
    logic [31:0] ad;
    logic [7:0] fa;
    logic hm, am, ard, fl, rm, g, hn, st;
    // in = {halt_req, host_req, host_we}; ex = {mem_we, host_ack, cpu_stall, cpu_rstn, halted}
    tv[0]  = mk(8'h00, 3'b000, 8'h00, 32'h0, 8'h00, 5'b00100, 1'b0, 32'h0);
    tv[1]  = mk(8'h00, 3'b000, 8'h00, 32'h0, 8'h00, 5'b00010, 1'b1, 32'h1000_0000);
    tv[2]  = mk(8'h00, 3'b010, 8'h10, 32'h0, 8'h10, 5'b00110, 1'b0, 32'h0);
    tv[3]  = mk(8'h00, 3'b000, 8'h00, 32'h0, 8'h00, 5'b01110, 1'b1, 32'hDEADBEEF);
    tv[4]  = mk(8'h00, 3'b000, 8'h00, 32'h0, 8'h00, 5'b00010, 1'b1, 32'h1000_0000);
    for (int i = 5; i <= 9; i += 2) begin
      tv[i]   = mk(8'h00, 3'b010, 8'h11, 32'h0, 8'h11, 5'b00110, 1'b0, 32'h0);
      tv[i+1] = mk(8'h00, 3'b010, 8'h11, 32'h0, 8'h00, 5'b01110, 1'b1, 32'h1000_0011);
    end
    tv[11] = mk(8'h00, 3'b000, 8'h00, 32'h0, 8'h00, 5'b00010, 1'b1, 32'h1000_0000);
    tv[12] = mk(8'h00, 3'b100, 8'h00, 32'h0, 8'h00, 5'b00010, 1'b1, 32'h1000_0000);
    tv[13] = mk(8'h00, 3'b111, 8'h00, 32'hA000_0000, 8'h00, 5'b10101, 1'b0, 32'h0);
    for (int i = 1; i < 4; i++)
      tv[13+i] = mk(8'h00, 3'b111, 8'(i), 32'hA000_0000 + 32'(i), 8'(i), 5'b11101, 1'b0, 32'h0);
    tv[17] = mk(8'h00, 3'b100, 8'h00, 32'h0, 8'h00, 5'b01101, 1'b0, 32'h0);
    tv[18] = mk(8'h00, 3'b000, 8'h00, 32'h0, 8'h00, 5'b00101, 1'b0, 32'h0);
    tv[19] = mk(8'h00, 3'b000, 8'h00, 32'h0, 8'h00, 5'b00110, 1'b0, 32'h0);
    tv[20] = mk(8'h00, 3'b000, 8'h00, 32'h0, 8'h00, 5'b00010, 1'b1, 32'hA000_0000);
    tv[21] = mk(8'h00, 3'b011, 8'h00, 32'hB000_0000, 8'h00, 5'b10110, 1'b0, 32'h0);
    tv[22] = mk(8'h00, 3'b000, 8'h00, 32'h0, 8'h00, 5'b01110, 1'b0, 32'h0);
    tv[23] = mk(8'h00, 3'b000, 8'h00, 32'h0, 8'h00, 5'b00010, 1'b1, 32'hB000_0000);
    repeat (3) @(posedge clk);
    load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      clrn = 1'b1;
      cpu_addr = tv[i].ca;
      {halt_req, host_req, host_we} = tv[i].in;
      host_addr = tv[i].ha;
      host_wdata = tv[i].wd;
      #1;
      chk($sformatf("r%0d mem_addr", i), 32'(mem_addr), 32'(tv[i].ma));
      chk($sformatf("r%0d mem_we", i), 32'(mem_we), 32'(tv[i].ex[4]));
      chk($sformatf("r%0d host_ack", i), 32'(host_ack), 32'(tv[i].ex[3]));
      chk($sformatf("r%0d cpu_stall", i), 32'(cpu_stall), 32'(tv[i].ex[2]));
      chk($sformatf("r%0d cpu_rstn", i), 32'(cpu_rstn), 32'(tv[i].ex[1]));
      chk($sformatf("r%0d halted", i), 32'(halted), 32'(tv[i].ex[0]));
      if (tv[i].dv) chk($sformatf("r%0d data", i), tv[i].ex[2] ? host_rdata : cpu_inst, tv[i].d);
    end
    // reset arriving while a host access is being acked
    @(negedge clk); host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12; #1;
    chk("rst grant addr", 32'(mem_addr), 32'h12);
    @(negedge clk); host_req = 1'b0; #1;
    chk("rst pre ack", 32'(host_ack), 32'h1);
    clrn = 1'b0; host_req = 1'b1; host_we = 1'b1; #1;
    chk("rst ack", 32'(host_ack), 32'h0);
    chk("rst mem_we", 32'(mem_we), 32'h0);
    chk("rst cpu_rstn", 32'(cpu_rstn), 32'h0);
    chk("rst halted", 32'(halted), 32'h0);
    chk("rst stall", 32'(cpu_stall), 32'h1);
    @(negedge clk); #1;
    chk("rst held ack", 32'(host_ack), 32'h0);
    @(negedge clk); clrn = 1'b1; host_req = 1'b0; host_we = 1'b0; #1;
    chk("rst rel rstn", 32'(cpu_rstn), 32'h0);
    chk("rst rel stall", 32'(cpu_stall), 32'h1);
    @(negedge clk); #1;
    chk("rst up rstn", 32'(cpu_rstn), 32'h1);
    chk("rst up ack", 32'(host_ack), 32'h0);
    chk("rst up halted", 32'(halted), 32'h0);
    chk("rst up stall", 32'(cpu_stall), 32'h0);
    chk("rst up inst", cpu_inst, 32'hB000_0000);
`ifdef IMEM_ARB_STATS_EN
    repeat (9) @(negedge clk);
    @(negedge clk); host_req = 1'b1; host_addr = 8'h10;
    @(negedge clk); host_req = 1'b0;
    @(negedge clk); #1;
    chk("stats fetch_cnt", fetch_cnt, 32'd10);
    chk("stats stall_cnt", stall_cnt, 32'd2);
`endif
    // randomized traffic against a rule-level model
    @(negedge clk);
    clrn = 1'b0; halt_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
    repeat (2) @(negedge clk);
    {hm, am, ard, fl, rm} = '0;
    fa = '0; ad = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        clrn = 1'b1;
        mm = mem;
      end
      if ($urandom_range(3) == 0) cpu_addr = 8'($urandom_range(7));
      if ($urandom_range(15) == 0) halt_req = ~halt_req;
      host_req = 1'($urandom_range(1));
      host_we = ($urandom_range(2) == 0);
      host_addr = 8'($urandom_range(7));
      host_wdata = $urandom;
      #1;
      // host may use the port when halted and still halting, or in run mode if not used last cycle and no halt pending
      g = host_req && (hm ? halt_req : !am && !halt_req);
      st = g || !(fl && fa == cpu_addr);
      chk("rand mem_addr", 32'(mem_addr), 32'(g ? host_addr : cpu_addr));
      chk("rand mem_we", 32'(mem_we), 32'(g && host_we));
      chk("rand host_ack", 32'(host_ack), 32'(am));
      if (am && ard) chk("rand host_rdata", host_rdata, ad);
      chk("rand cpu_stall", 32'(cpu_stall), 32'(st));
      if (!st) chk("rand cpu_inst", cpu_inst, mm[cpu_addr]);
      chk("rand cpu_rstn", 32'(cpu_rstn), 32'(rm));
      chk("rand halted", 32'(halted), 32'(hm));
      hn = hm ? (halt_req || am) : halt_req;
      fl = !g && !hm;
      fa = cpu_addr;
      if (g) begin
        ad = mm[host_addr];
        ard = !host_we;
        if (host_we) mm[host_addr] = host_wdata;
      end
      am = g;
      hm = hn;
      rm = !hn;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
